// File: rtl/io_map_pkg.sv
// Shared I/O register map for the timer/key block and the bus hub:
// window base, register offsets and CTRL/STATUS bit positions.
package io_map;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_00C0;

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_LOAD   = 3'd1,
    OFF_COUNT  = 3'd2,
    OFF_STATUS = 3'd3,
    OFF_KEYS   = 3'd4
  } reg_off_e;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_RELOAD      = 1;
  localparam int CTRL_TIE         = 2;
  localparam int CTRL_KIE         = 3;
  localparam int STATUS_EXP       = 0;
  localparam int STATUS_KEYEV_LSB = 4;

  typedef struct packed {
    logic kie;
    logic tie;
    logic reload;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] pack_status(input logic exp_flag, input logic [3:0] keyev);
    logic [31:0] s;
    s = '0;
    s[STATUS_EXP] = exp_flag;
    s[STATUS_KEYEV_LSB +: 4] = keyev;
    return s;
  endfunction

endpackage

// File: rtl/sc_key_debounce.sv
// One push-button: 2-flop synchronizer into a stability counter that
// only accepts a new level after DB_CYCLES consecutive cycles.
module sc_key_debounce
#(
  parameter int DB_CYCLES = 250000
)
(
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_cnt;
  logic          pressed;
  logic          differ;
  logic          accept;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], key_n};
  end

  assign pressed = ~sync_q[1];
  assign differ  = (pressed != level);
  assign accept  = differ && (stable_cnt == CNT_MAX);
  assign press   = accept && pressed;

  // Any bounce back to the accepted level restarts the stability count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (!differ) begin
      stable_cnt <= '0;
    end else if (accept) begin
      stable_cnt <= '0;
      level      <= pressed;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_io_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and
// four debounced push-buttons, sharing one interrupt line.
module sc_io_timer
  import io_map::*;
#(
  parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
  parameter int          PRESC     = 50000,
  parameter int          DB_CYCLES = 250000
)
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        hit,
  input  logic [3:0]  KEY,
  output logic        irq
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  ctrl_t         ctrl;
  logic [31:0]   load;
  logic [31:0]   count;
  logic [31:0]   count_next;
  logic          exp_flag;
  logic          exp_next;
  logic          exp_set;
  logic [3:0]    keyev;
  logic [3:0]    keyev_next;
  logic [3:0]    keys;
  logic [3:0]    key_press;
  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic [31:0]   win_off;
  logic [2:0]    reg_sel;
  logic          wr;
  logic          status_wr;
  logic [31:0]   rd_data;

  assign win_off   = addr - IO_BASE;
  assign hit       = (addr >= IO_BASE) && (win_off < 32'd32);
  assign reg_sel   = addr[4:2];
  assign wr        = we && hit;
  assign status_wr = wr && (reg_sel == OFF_STATUS);

  for (genvar k = 0; k < 4; k++) begin : g_key
    sc_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (KEY[k]),
      .level  (keys[k]),
      .press  (key_press[k])
    );
  end

  assign tick = ctrl.en && (presc_cnt == PRESC_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)               presc_cnt <= '0;
    else if (!ctrl.en || tick) presc_cnt <= '0;
    else                       presc_cnt <= presc_cnt + 1'b1;
  end

  // A CPU store to COUNT overrides a coincident tick entirely, EXP included.
  always_comb begin
    count_next = count;
    exp_set    = 1'b0;
    if (wr && (reg_sel == OFF_COUNT)) begin
      count_next = datain;
    end else if (tick) begin
      if (count != 32'd0) begin
        count_next = count - 32'd1;
        exp_set    = (count == 32'd1);
      end else if (ctrl.reload) begin
        count_next = load;
        exp_set    = 1'b1;
      end
    end
  end

  assign exp_next   = (exp_flag & ~(status_wr & datain[STATUS_EXP])) | exp_set;
  assign keyev_next = (keyev & ~({4{status_wr}} & datain[STATUS_KEYEV_LSB +: 4])) | key_press;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ctrl     <= '0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      keyev    <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && (reg_sel == OFF_CTRL)) ctrl <= ctrl_t'(datain[3:0]);
      if (wr && (reg_sel == OFF_LOAD)) load <= datain;
      count    <= count_next;
      exp_flag <= exp_next;
      keyev    <= keyev_next;
      irq      <= (exp_flag & ctrl.tie) | ((|keyev) & ctrl.kie);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      OFF_CTRL:   rd_data = {28'd0, ctrl};
      OFF_LOAD:   rd_data = load;
      OFF_COUNT:  rd_data = count;
      OFF_STATUS: rd_data = pack_status(exp_flag, keyev);
      OFF_KEYS:   rd_data = {28'd0, keys};
      default:    rd_data = '0;
    endcase
    dataout = hit ? rd_data : 32'd0;
  end

endmodule

// File: tb/tb_sc_io_timer.sv
// Bench for sc_io_timer with a fast prescaler and short debounce window;
// expected read values go through a small scoreboard queue.
module tb_sc_io_timer;

  localparam logic [31:0] BASE = 32'h0000_00C0;
  localparam int R_CTRL   = 0;
  localparam int R_LOAD   = 1;
  localparam int R_COUNT  = 2;
  localparam int R_STATUS = 3;
  localparam int R_KEYS   = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic        hit;
  logic [3:0]  KEY;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  sc_io_timer #(.IO_BASE(BASE), .PRESC(2), .DB_CYCLES(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .dataout (dataout),
    .hit     (hit),
    .KEY     (KEY),
    .irq     (irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic writeReg(input int off, input logic [31:0] d);
    applyStimulus(BASE + 32'(off * 4), d);
  endtask

  task automatic expectRead(input string tag, input logic [31:0] a, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
    addr = a;
    #1;
    e = sb_q.pop_front();
    checkOutput(e.tag, dataout, e.value);
  endtask

  task automatic expectReg(input string tag, input int off, input logic [31:0] value);
    expectRead(tag, BASE + 32'(off * 4), value);
  endtask

  task automatic expectHit(input string tag, input logic [31:0] a, input logic value);
    addr = a;
    #1;
    checkOutput(tag, {31'd0, hit}, {31'd0, value});
  endtask

  task automatic expectIrq(input string tag, input logic value);
    checkOutput(tag, {31'd0, irq}, {31'd0, value});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addr   = BASE + 32'h20;
    datain = '0;
    we     = 1'b0;
    KEY    = 4'hF;
    resetn = 1'b0;
    step(2);

    expectReg("rst_ctrl",   R_CTRL,   32'h0);
    expectReg("rst_load",   R_LOAD,   32'h0);
    expectReg("rst_count",  R_COUNT,  32'h0);
    expectReg("rst_status", R_STATUS, 32'h0);
    expectReg("rst_keys",   R_KEYS,   32'h0);
    expectIrq("rst_irq", 1'b0);
    resetn = 1'b1;
    step(1);

    // Auto-reload countdown: 3 -> 2,1,0,3 every two cycles.
    writeReg(R_LOAD, 32'd3);
    writeReg(R_COUNT, 32'd3);
    writeReg(R_CTRL, 32'h3);
    step(2); expectReg("rl_cnt2", R_COUNT, 32'd2);
    step(2); expectReg("rl_cnt1", R_COUNT, 32'd1);
    step(2); expectReg("rl_cnt0", R_COUNT, 32'd0);
    expectReg("rl_exp_first", R_STATUS, 32'h1);
    writeReg(R_STATUS, 32'h1);
    expectReg("rl_exp_cleared", R_STATUS, 32'h0);
    step(1); expectReg("rl_cnt_reload", R_COUNT, 32'd3);
    expectReg("rl_exp_again", R_STATUS, 32'h1);
    expectIrq("rl_irq_tie_off", 1'b0);
    writeReg(R_CTRL, 32'h0);
    writeReg(R_STATUS, 32'h1);

    // W1C of EXP coinciding with the expiring tick: the set must win.
    writeReg(R_COUNT, 32'd1);
    writeReg(R_CTRL, 32'h5);
    step(1);
    writeReg(R_STATUS, 32'h1);
    expectReg("race_exp", R_STATUS, 32'h1);
    expectReg("race_cnt", R_COUNT, 32'd0);
    expectIrq("race_irq_lag", 1'b0);
    step(1);
    expectIrq("race_irq", 1'b1);

    // One-shot mode: EXP once, COUNT parks at 0.
    writeReg(R_CTRL, 32'h0);
    writeReg(R_STATUS, 32'h1);
    writeReg(R_COUNT, 32'd1);
    writeReg(R_CTRL, 32'h1);
    step(4);
    expectReg("os_cnt", R_COUNT, 32'd0);
    expectReg("os_exp", R_STATUS, 32'h1);
    expectIrq("os_irq", 1'b0);
    writeReg(R_STATUS, 32'h1);
    expectReg("os_exp_clr", R_STATUS, 32'h0);
    step(6);
    expectReg("os_exp_stays", R_STATUS, 32'h0);
    expectReg("os_cnt_hold", R_COUNT, 32'd0);

    // LOAD=0 with reload: EXP on every tick.
    writeReg(R_CTRL, 32'h0);
    writeReg(R_STATUS, 32'h1);
    writeReg(R_LOAD, 32'd0);
    writeReg(R_COUNT, 32'd0);
    writeReg(R_CTRL, 32'h3);
    step(2);
    expectReg("l0_exp1", R_STATUS, 32'h1);
    expectReg("l0_cnt", R_COUNT, 32'd0);
    writeReg(R_STATUS, 32'h1);
    expectReg("l0_clr", R_STATUS, 32'h0);
    step(1);
    expectReg("l0_exp2", R_STATUS, 32'h1);

    // CPU write to COUNT beats a coincident tick.
    writeReg(R_CTRL, 32'h0);
    writeReg(R_STATUS, 32'h1);
    writeReg(R_COUNT, 32'd10);
    writeReg(R_CTRL, 32'h1);
    step(1);
    writeReg(R_COUNT, 32'd7);
    expectReg("wr_wins", R_COUNT, 32'd7);
    step(2);
    expectReg("wr_then_tick", R_COUNT, 32'd6);
    expectReg("wr_no_exp", R_STATUS, 32'h0);
    writeReg(R_CTRL, 32'h0);

    // Address decode and unused offsets.
    applyStimulus(BASE + 32'h05, 32'hDEAD_BEEF);
    expectReg("alias_load", R_LOAD, 32'hDEAD_BEEF);
    expectRead("off5_zero", BASE + 32'h14, 32'h0);
    applyStimulus(BASE + 32'h18, 32'h0000_1234);
    expectRead("off6_zero", BASE + 32'h18, 32'h0);
    expectReg("load_intact", R_LOAD, 32'hDEAD_BEEF);
    expectRead("beyond_data", BASE + 32'h20, 32'h0);
    expectHit("beyond_hit", BASE + 32'h20, 1'b0);
    expectHit("below_hit", BASE - 32'h4, 1'b0);
    expectHit("top_hit", BASE + 32'h1F, 1'b1);
    writeReg(R_CTRL, 32'hFFFF_FFF0);
    expectReg("ctrl_undef", R_CTRL, 32'h0);
    applyStimulus(BASE + 32'h20, 32'h0000_000F);
    expectReg("ctrl_outside_wr", R_CTRL, 32'h0);

    // Key debounce: a 3-cycle glitch is ignored, a long press is taken.
    writeReg(R_CTRL, 32'h8);
    writeReg(R_STATUS, 32'hFF);
    KEY = 4'b1011;
    step(3);
    KEY = 4'hF;
    step(10);
    expectReg("glitch_keys", R_KEYS, 32'h0);
    expectReg("glitch_status", R_STATUS, 32'h0);
    expectIrq("glitch_irq", 1'b0);
    KEY = 4'b1011;
    step(10);
    expectReg("press_keys", R_KEYS, 32'h4);
    expectReg("press_status", R_STATUS, 32'h40);
    expectIrq("press_irq", 1'b1);
    writeReg(R_STATUS, 32'h1);
    expectReg("w1c_other_bit", R_STATUS, 32'h40);
    KEY = 4'hF;
    step(10);
    expectReg("release_keys", R_KEYS, 32'h0);
    expectReg("release_no_ev", R_STATUS, 32'h40);
    writeReg(R_STATUS, 32'h40);
    expectReg("keyev_clr", R_STATUS, 32'h0);
    expectIrq("keyev_irq_lag", 1'b1);
    step(1);
    expectIrq("keyev_irq_off", 1'b0);

    // Reset in the middle of a countdown with a key event pending.
    writeReg(R_CTRL, 32'h0);
    KEY = 4'b1101;
    step(8);
    writeReg(R_LOAD, 32'd9);
    writeReg(R_COUNT, 32'd5);
    writeReg(R_CTRL, 32'h9);
    step(3);
    expectReg("pre_rst_cnt", R_COUNT, 32'd4);
    expectReg("pre_rst_status", R_STATUS, 32'h20);
    expectIrq("pre_rst_irq", 1'b1);
    resetn = 1'b0;
    KEY    = 4'hF;
    expectReg("mid_rst_ctrl", R_CTRL, 32'h0);
    expectReg("mid_rst_load", R_LOAD, 32'h0);
    expectReg("mid_rst_count", R_COUNT, 32'h0);
    expectReg("mid_rst_status", R_STATUS, 32'h0);
    expectReg("mid_rst_keys", R_KEYS, 32'h0);
    expectIrq("mid_rst_irq", 1'b0);
    step(1);
    resetn = 1'b1;
    step(1);
    writeReg(R_COUNT, 32'd5);
    step(6);
    expectReg("post_rst_cnt", R_COUNT, 32'd5);
    expectReg("post_rst_status", R_STATUS, 32'h0);
    expectIrq("post_rst_irq", 1'b0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
